// File: rtl/switch_debounce_scanner.sv
// switch_debounce_scanner: 2-FF sync, per-bit debounce and edge strobes for the slide switches.
// Edge strobes are built only when SW_EDGE_DETECT_EN is defined; otherwise they are tied to 0.
module switch_debounce_scanner #(
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic            CLOCK_50,
    input  logic            RST,
    input  logic [N_SW-1:0] SW,
    output logic [N_SW-1:0] sw_stable,
    output logic [3:0]      hex_lo,
    output logic [3:0]      hex_hi,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            update
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  meta_q, sync_q, stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q [N_SW];
    logic [CNT_W-1:0] cnt_d [N_SW];

    // A match clears the count, so any partial glitch is forgotten.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N_SW; i++) begin
            cnt_d[i]    = (sync_q[i] == stable_q[i] || cnt_q[i] == CNT_TERM) ? '0 : cnt_q[i] + CNT_W'(1);
            stable_d[i] = (sync_q[i] != stable_q[i] && cnt_q[i] == CNT_TERM) ? sync_q[i] : stable_q[i];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            meta_q   <= '0;
            sync_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '{default: '0};
        end else begin
            meta_q   <= SW;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sw_stable = stable_q;
    assign hex_lo    = stable_q[3:0];
    assign hex_hi    = stable_q[7:4];

`ifdef SW_EDGE_DETECT_EN
    logic [N_SW-1:0] rise_q, fall_q;
    logic            update_q;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            rise_q   <= '0;
            fall_q   <= '0;
            update_q <= 1'b0;
        end else begin
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
            update_q <= |(stable_d ^ stable_q);
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
    assign update  = update_q;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
    assign update  = 1'b0;
`endif
endmodule

// File: tb/tb_switch_debounce_scanner.sv
// tb_switch_debounce_scanner: scoreboard bench for switch_debounce_scanner (DEBOUNCE_CYCLES=4).
module tb_switch_debounce_scanner;
`ifdef SW_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    localparam int K_STB = 0, K_RISE = 1, K_FALL = 2, K_UPD = 3, K_LO = 4, K_HI = 5;

    logic       CLOCK_50 = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] SW = '0;
    logic [9:0] sw_stable, sw_rise, sw_fall;
    logic [3:0] hex_lo, hex_hi;
    logic       update;

    switch_debounce_scanner #(.N_SW(10), .DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50(CLOCK_50), .RST(RST), .SW(SW),
        .sw_stable(sw_stable), .hex_lo(hex_lo), .hex_hi(hex_hi),
        .sw_rise(sw_rise), .sw_fall(sw_fall), .update(update)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int         c;
        int         k;
        logic [9:0] v;
        string      tag;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_at(input int c, input int k, input logic [9:0] v, input string tag);
        exp_t e;
        int i = 0;
        e = '{c, k, v, tag};
        while (i < sb.size() && sb[i].c <= c) i++;
        sb.insert(i, e);
    endtask

    function automatic logic [9:0] eg(input logic [9:0] v);
        return EDGE ? v : 10'h000;
    endfunction

    function automatic logic [9:0] obs(input int k);
        return k == K_STB  ? sw_stable :
               k == K_RISE ? sw_rise :
               k == K_FALL ? sw_fall :
               k == K_UPD  ? {9'b0, update} :
               k == K_LO   ? {6'b0, hex_lo} : {6'b0, hex_hi};
    endfunction

    always @(negedge CLOCK_50)
        while (sb.size() > 0 && sb[0].c == cyc) begin
            mon_e = sb.pop_front();
            chk(mon_e.tag, obs(mon_e.k), mon_e.v);
        end

    task automatic expect_zero(input int c, input string tag);
        for (int k = 0; k < 6; k++) expect_at(c, k, '0, tag);
    endtask

    // Stable changes old->new at cycle c, strobes last exactly one cycle.
    task automatic expect_change(input int c, input logic [9:0] o, input logic [9:0] n, input string tag);
        expect_at(c - 1, K_STB,  o, {tag, "_pre"});
        expect_at(c - 1, K_UPD,  '0, {tag, "_upd_pre"});
        expect_at(c,     K_STB,  n, {tag, "_stb"});
        expect_at(c,     K_LO,   {6'b0, n[3:0]}, {tag, "_lo"});
        expect_at(c,     K_HI,   {6'b0, n[7:4]}, {tag, "_hi"});
        expect_at(c,     K_RISE, eg(n & ~o), {tag, "_rise"});
        expect_at(c,     K_FALL, eg(o & ~n), {tag, "_fall"});
        expect_at(c,     K_UPD,  eg(10'h001), {tag, "_upd"});
        expect_at(c + 1, K_RISE, '0, {tag, "_rise_end"});
        expect_at(c + 1, K_FALL, '0, {tag, "_fall_end"});
        expect_at(c + 1, K_UPD,  '0, {tag, "_upd_end"});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    int g, f;

    initial begin
        RST = 1'b1;
        SW  = 10'h3FF;
        for (int i = 1; i <= 3; i++) expect_zero(i, "rst");
        tick(3);
        RST = 1'b0;
        expect_change(cyc + 6, 10'h000, 10'h3FF, "settle");
        tick(8);
        SW = 10'h000;
        expect_change(cyc + 6, 10'h3FF, 10'h000, "clear");
        tick(10);

        g  = cyc;
        SW = 10'h001;
        for (int i = 1; i <= 10; i++) begin
            expect_at(g + i, K_STB, '0, "glitch_stb");
            expect_at(g + i, K_UPD, '0, "glitch_upd");
        end
        tick(3);
        SW = 10'h000;
        tick(10);

        expect_change(cyc + 6, 10'h000, 10'h0A5, "clean");
        SW = 10'h0A5;
        tick(10);

        f  = cyc;
        SW = 10'h085;
        expect_at(f + 5, K_STB,  10'h0A5, "fall_pre");
        expect_at(f + 6, K_STB,  10'h085, "fall_stb");
        expect_at(f + 6, K_FALL, eg(10'h020), "fall5");
        expect_at(f + 6, K_RISE, '0, "fall_norise");
        expect_at(f + 6, K_UPD,  eg(10'h001), "fall_upd");
        expect_at(f + 7, K_FALL, '0, "fall5_end");
        tick(2);
        SW = 10'h285;
        expect_change(cyc + 6, 10'h085, 10'h285, "rise9");
        tick(10);

        SW = 10'h28D;
        tick(3);
        RST = 1'b1;
        expect_zero(cyc + 1, "rstmid_rst");
        tick(1);
        RST = 1'b0;
        expect_change(cyc + 6, 10'h000, 10'h28D, "rstmid");
        tick(10);

        chk("leftover", 10'(sb.size()), 10'h000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
